// File: rtl/maindec_mc.sv
// maindec_mc: multicycle MIPS main control FSM driving datapath enables, muxes and aluop
module maindec_mc (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op,
  input  logic       memready,
  output logic       memwrite,
  output logic       irwrite,
  output logic       pcwrite,
  output logic       branch,
  output logic       regwrite,
  output logic       iord,
  output logic       memtoreg,
  output logic       regdst,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic       zeroext,
  output logic [1:0] pcsrc,
  output logic [1:0] aluop,
  output logic       illegal,
  output logic [3:0] state
);
  typedef enum logic [3:0] {
    FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXECUTE,
    ALUWB, BRANCH, ADDIEX, IWB, JUMP, ORIEX
  } state_t;
  state_t cur, nxt;
  always_ff @(posedge clk or negedge reset)
    if (!reset) cur <= FETCH;
    else cur <= nxt;
  assign state = cur;
  always_comb begin
    nxt = FETCH;
    case (cur)
      FETCH:   nxt = memready ? DECODE : FETCH;
      DECODE:
        case (op)
          6'b100011, 6'b101011: nxt = MEMADR;
          6'b000000:            nxt = EXECUTE;
          6'b000100:            nxt = BRANCH;
          6'b001000:            nxt = ADDIEX;
          6'b001101:            nxt = ORIEX;
          6'b000010:            nxt = JUMP;
          default:              nxt = FETCH;
        endcase
      MEMADR:  nxt = op == 6'b101011 ? MEMWR : MEMRD;
      MEMRD:   nxt = memready ? MEMWB : MEMRD;
      MEMWR:   nxt = memready ? FETCH : MEMWR;
      EXECUTE: nxt = ALUWB;
      ADDIEX:  nxt = IWB;
      ORIEX:   nxt = IWB;
      default: nxt = FETCH;
    endcase
  end
  always_comb begin
    memwrite = 1'b0;
    irwrite  = 1'b0;
    pcwrite  = 1'b0;
    branch   = 1'b0;
    regwrite = 1'b0;
    iord     = 1'b0;
    memtoreg = 1'b0;
    regdst   = 1'b0;
    alusrca  = 1'b0;
    alusrcb  = 2'b00;
    zeroext  = 1'b0;
    pcsrc    = 2'b00;
    aluop    = 2'b00;
    illegal  = 1'b0;
    if (reset)
      case (cur)
        FETCH: begin
          alusrcb = 2'b01;
          irwrite = memready;
          pcwrite = memready;
        end
        DECODE: begin
          alusrcb = 2'b11;
          illegal = !(op inside {6'b100011, 6'b101011, 6'b000000, 6'b000100,
                                 6'b001000, 6'b001101, 6'b000010});
        end
        MEMADR: begin
          alusrca = 1'b1;
          alusrcb = 2'b10;
        end
        MEMRD: iord = 1'b1;
        MEMWR: begin
          iord     = 1'b1;
          memwrite = 1'b1;
        end
        MEMWB: begin
          memtoreg = 1'b1;
          regwrite = 1'b1;
        end
        EXECUTE: begin
          alusrca = 1'b1;
          aluop   = 2'b10;
        end
        ALUWB: begin
          regdst   = 1'b1;
          regwrite = 1'b1;
        end
        BRANCH: begin
          alusrca = 1'b1;
          aluop   = 2'b01;
          pcsrc   = 2'b01;
          branch  = 1'b1;
        end
        ADDIEX: begin
          alusrca = 1'b1;
          alusrcb = 2'b10;
        end
        ORIEX: begin
          alusrca = 1'b1;
          alusrcb = 2'b10;
          zeroext = 1'b1;
          aluop   = 2'b11;
        end
        IWB: regwrite = 1'b1;
        JUMP: begin
          pcsrc   = 2'b10;
          pcwrite = 1'b1;
        end
        default: ;
      endcase
  end
endmodule

// File: tb/tb_maindec_mc.sv
// tb_maindec_mc: scoreboard bench for maindec_mc state sequencing and per-state outputs
module tb_maindec_mc;
  logic       clk, reset, memready;
  logic [5:0] op;
  logic       memwrite, irwrite, pcwrite, branch, regwrite, iord, memtoreg, regdst, alusrca;
  logic [1:0] alusrcb, pcsrc, aluop;
  logic       zeroext, illegal;
  logic [3:0] state;
  logic [16:0] dv;
  int n_chk = 0;
  int n_fail = 0;
  typedef struct {
    string       tag;
    logic [3:0]  st;
    logic [16:0] v;
  } exp_t;
  exp_t sb[$];
  maindec_mc dut (
    .clk(clk), .reset(reset), .op(op), .memready(memready),
    .memwrite(memwrite), .irwrite(irwrite), .pcwrite(pcwrite), .branch(branch),
    .regwrite(regwrite), .iord(iord), .memtoreg(memtoreg), .regdst(regdst),
    .alusrca(alusrca), .alusrcb(alusrcb), .zeroext(zeroext), .pcsrc(pcsrc),
    .aluop(aluop), .illegal(illegal), .state(state)
  );
  assign dv = {memwrite, irwrite, pcwrite, branch, regwrite, iord, memtoreg, regdst,
               alusrca, alusrcb, zeroext, pcsrc, aluop, illegal};
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask
  function automatic logic legal(input logic [5:0] o);
    return o inside {6'b100011, 6'b101011, 6'b000000, 6'b000100, 6'b001000, 6'b001101, 6'b000010};
  endfunction
  function automatic logic [16:0] exp_vec(input logic [3:0] s, input logic mr, input logic ill);
    logic mw, ir, pw, br, rw, io, mt, rd, sa, zx, il;
    logic [1:0] sb_, ps, ao;
    {mw, ir, pw, br, rw, io, mt, rd, sa, zx, il} = '0;
    {sb_, ps, ao} = '0;
    case (s)
      4'd0:  begin sb_ = 2'b01; ir = mr; pw = mr; end
      4'd1:  begin sb_ = 2'b11; il = ill; end
      4'd2:  begin sa = 1; sb_ = 2'b10; end
      4'd3:  io = 1;
      4'd4:  begin mt = 1; rw = 1; end
      4'd5:  begin io = 1; mw = 1; end
      4'd6:  begin sa = 1; ao = 2'b10; end
      4'd7:  begin rd = 1; rw = 1; end
      4'd8:  begin sa = 1; ao = 2'b01; ps = 2'b01; br = 1; end
      4'd9:  begin sa = 1; sb_ = 2'b10; end
      4'd10: rw = 1;
      4'd11: begin ps = 2'b10; pw = 1; end
      4'd12: begin sa = 1; sb_ = 2'b10; zx = 1; ao = 2'b11; end
      default: ;
    endcase
    return {mw, ir, pw, br, rw, io, mt, rd, sa, sb_, zx, ps, ao, il};
  endfunction
  always @(negedge clk)
    while (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      chk({e.tag, "_state"}, {28'd0, state}, {28'd0, e.st});
      chk({e.tag, "_out"}, {15'd0, dv}, {15'd0, e.v});
    end
  task automatic rstep(input string tag);
    reset = 1'b0;
    memready = 1'b1;
    sb.push_back('{tag, 4'd0, 17'd0});
    @(posedge clk); #1;
  endtask
  task automatic step(input string tag, input logic [5:0] o, input logic mr, input logic [3:0] s);
    reset = 1'b1;
    op = o;
    memready = mr;
    sb.push_back('{tag, s, exp_vec(s, mr, s == 4'd1 && !legal(o))});
    @(posedge clk); #1;
  endtask
  task automatic instr(input string tag, input logic [5:0] o, input int n,
                       input logic [63:0] seq, input logic [15:0] mr);
    for (int i = 0; i < n; i++) step(tag, o, mr[i], seq[i*4 +: 4]);
  endtask
  initial begin
    reset = 1'b0;
    memready = 1'b1;
    op = 6'b0;
    @(posedge clk); #1;
    rstep("rst0");
    rstep("rst1");
    instr("lw",      6'b100011, 5, 64'h43210,   16'hFFFF);
    instr("rtype",   6'b000000, 4, 64'h7610,    16'hFFFF);
    instr("ori",     6'b001101, 4, 64'hAC10,    16'hFFFF);
    instr("beq",     6'b000100, 3, 64'h810,     16'hFFFF);
    instr("addi",    6'b001000, 4, 64'hA910,    16'h0001);
    instr("j",       6'b000010, 3, 64'hB10,     16'hFFFF);
    instr("sw_stl",  6'b101011, 7, 64'h5555210, 16'h0047);
    instr("if_stl",  6'b000000, 6, 64'h761000,  16'h003C);
    instr("illegal", 6'b111111, 2, 64'h10,      16'hFFFF);
    instr("lw_stl",  6'b100011, 6, 64'h433210,  16'h0037);
    instr("sw_abrt", 6'b101011, 4, 64'h5210,    16'h0007);
    chk("abrt_pre_state", {28'd0, state}, 32'd5);
    #3 reset = 1'b0;
    #1;
    chk("abrt_state", {28'd0, state}, 32'd0);
    chk("abrt_memwrite", {31'd0, memwrite}, 32'd0);
    @(posedge clk); #1;
    rstep("rst2");
    instr("rtype2",  6'b000000, 4, 64'h7610,    16'hFFFF);
    step("tail", 6'b000000, 1'b0, 4'd0);
    @(negedge clk); #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
  initial begin
    #100000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1);
  end
endmodule
